// File: rtl/alarm_pkg.sv
// Shared constants for the multi-alarm controller.
//   HR_W / MIN_W / SEC_W : field widths of the time-of-day inputs and alarm slots
//   MAX_HR / MAX_MIN     : largest legal hour / minute accepted by a slot write
//   S_IDLE/S_RING/S_SNOOZE : FSM state encodings
//   cnt_width / sel_width  : sizing helpers that never return a zero width
package alarm_pkg;

    localparam int HR_W  = 5;
    localparam int MIN_W = 6;
    localparam int SEC_W = 6;

    localparam logic [HR_W-1:0]  MAX_HR  = 5'd23;
    localparam logic [MIN_W-1:0] MAX_MIN = 6'd59;

    localparam int STATE_W = 2;
    localparam logic [STATE_W-1:0] S_IDLE   = 2'd0;
    localparam logic [STATE_W-1:0] S_RING   = 2'd1;
    localparam logic [STATE_W-1:0] S_SNOOZE = 2'd2;

    // Bits needed to hold 0..max_val; at least one bit so a zero limit still elaborates.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    // Bits needed to index n slots; at least one bit for a single-slot build.
    function automatic int sel_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/beep_gen.sv
// Square-wave generator for the buzzer.
//   clk_100MHz : system clock
//   reset      : synchronous, active-high
//   en         : run enable; while low the divider and phase are held at zero
//   wave       : phase gated by en, toggles every BEEP_DIV cycles while enabled
// Because phase restarts low on every rise of en, the first high half-period is a full
// BEEP_DIV cycles rather than a truncated one.
module beep_gen #(
    parameter int unsigned BEEP_DIV = 50000
) (
    input  logic clk_100MHz,
    input  logic reset,
    input  logic en,
    output logic wave
);

    localparam int CNT_W = (BEEP_DIV <= 1) ? 1 : $clog2(BEEP_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BEEP_DIV - 1);

    logic [CNT_W-1:0] beep_cnt;
    logic             phase;

    always_ff @(posedge clk_100MHz) begin
        if (reset || !en) begin
            beep_cnt <= '0;
            phase    <= 1'b0;
        end else if (beep_cnt == CNT_LAST) begin
            beep_cnt <= '0;
            phase    <= ~phase;
        end else begin
            beep_cnt <= beep_cnt + 1'b1;
        end
    end

    assign wave = phase && en;

endmodule

// File: rtl/multi_alarm_ctrl.sv
// Multi-slot HH:MM alarm controller with snooze, dismiss and ring timeout.
//   clk_100MHz, reset : system clock, synchronous active-high reset
//   sec_tick          : one-cycle pulse per second from timekeeping
//   cur_hr/min/sec    : running time of day
//   alarm_en          : global enable; low forces IDLE and silences the buzzer
//   wr_en/sel/hr/min/arm : slot write port (out-of-range writes are dropped)
//   snooze, dismiss   : one-cycle user pulses
//   buzzer            : gated square wave, only while ringing
//   ringing, snoozing : FSM status
//   active_id         : slot that started the current RING/SNOOZE
//   armed_mask        : arm bits of all slots
module multi_alarm_ctrl
    import alarm_pkg::*;
#(
    parameter int unsigned NUM_ALARMS = 4,
    parameter int unsigned SNOOZE_SEC = 300,
    parameter int unsigned RING_SEC   = 60,
    parameter int unsigned BEEP_DIV   = 50000,
    localparam int SEL_W = sel_width(NUM_ALARMS)
) (
    input  logic                  clk_100MHz,
    input  logic                  reset,
    input  logic                  sec_tick,
    input  logic [HR_W-1:0]       cur_hr,
    input  logic [MIN_W-1:0]      cur_min,
    input  logic [SEC_W-1:0]      cur_sec,
    input  logic                  alarm_en,
    input  logic                  wr_en,
    input  logic [SEL_W-1:0]      wr_sel,
    input  logic [HR_W-1:0]       wr_hr,
    input  logic [MIN_W-1:0]      wr_min,
    input  logic                  wr_arm,
    input  logic                  snooze,
    input  logic                  dismiss,
    output logic                  buzzer,
    output logic                  ringing,
    output logic                  snoozing,
    output logic [SEL_W-1:0]      active_id,
    output logic [NUM_ALARMS-1:0] armed_mask
);

    localparam int RING_W = cnt_width(int'(RING_SEC));
    localparam int SNZ_W  = cnt_width(int'(SNOOZE_SEC));

    // ------------------------------------------------------------------
    // Alarm slots
    // ------------------------------------------------------------------
    logic [NUM_ALARMS-1:0][HR_W-1:0]  slot_hr;
    logic [NUM_ALARMS-1:0][MIN_W-1:0] slot_min;
    logic [NUM_ALARMS-1:0]            slot_armed;
    logic                             wr_ok;

    assign wr_ok = wr_en && (wr_hr <= MAX_HR) && (wr_min <= MAX_MIN)
                   && (32'(wr_sel) < NUM_ALARMS);

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            slot_hr    <= '0;
            slot_min   <= '0;
            slot_armed <= '0;
        end else begin
            for (int i = 0; i < int'(NUM_ALARMS); i++) begin
                if (wr_ok && (32'(wr_sel) == i)) begin
                    slot_hr[i]    <= wr_hr;
                    slot_min[i]   <= wr_min;
                    slot_armed[i] <= wr_arm;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Match detection with lowest-index priority
    // ------------------------------------------------------------------
    logic                  on_minute;
    logic [NUM_ALARMS-1:0] match_vec;
    logic                  match_any;
    logic [SEL_W-1:0]      match_id;

    assign on_minute = sec_tick && (cur_sec == '0);

    always_comb begin
        match_vec = '0;
        for (int i = 0; i < int'(NUM_ALARMS); i++) begin
            match_vec[i] = slot_armed[i] && (slot_hr[i] == cur_hr)
                           && (slot_min[i] == cur_min) && on_minute;
        end
    end

    // Walking downward lets the lowest matching index overwrite the others.
    always_comb begin
        match_any = 1'b0;
        match_id  = '0;
        for (int i = int'(NUM_ALARMS) - 1; i >= 0; i--) begin
            if (match_vec[i]) begin
                match_any = 1'b1;
                match_id  = SEL_W'(i);
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM and second counters
    // ------------------------------------------------------------------
    logic [STATE_W-1:0] state_q, state_d;
    logic [RING_W-1:0]  ring_cnt_q, ring_cnt_d;
    logic [SNZ_W-1:0]   snooze_cnt_q, snooze_cnt_d;
    logic [SEL_W-1:0]   active_id_q, active_id_d;
    logic               ring_last;
    logic               ring_full;
    logic               snz_last;

    // RING_SEC of zero disables the timeout entirely.
    assign ring_last = (RING_SEC != 0) && ((32'(ring_cnt_q) + 32'd1) == RING_SEC);
    assign ring_full = (32'(ring_cnt_q) >= RING_SEC);
    assign snz_last  = ((32'(snooze_cnt_q) + 32'd1) >= SNOOZE_SEC);

    always_comb begin
        state_d      = state_q;
        ring_cnt_d   = ring_cnt_q;
        snooze_cnt_d = snooze_cnt_q;
        active_id_d  = active_id_q;

        if (!alarm_en) begin
            state_d      = S_IDLE;
            ring_cnt_d   = '0;
            snooze_cnt_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    ring_cnt_d   = '0;
                    snooze_cnt_d = '0;
                    if (match_any) begin
                        state_d     = S_RING;
                        active_id_d = match_id;
                    end
                end
                S_RING: begin
                    // Matches here are intentionally dropped, not queued.
                    if (dismiss) begin
                        state_d    = S_IDLE;
                        ring_cnt_d = '0;
                    end else if (snooze) begin
                        state_d      = S_SNOOZE;
                        snooze_cnt_d = '0;
                    end else if (sec_tick) begin
                        if (ring_last) begin
                            state_d    = S_IDLE;
                            ring_cnt_d = '0;
                        end else if (!ring_full) begin
                            ring_cnt_d = ring_cnt_q + 1'b1;
                        end
                    end
                end
                S_SNOOZE: begin
                    if (dismiss) begin
                        state_d      = S_IDLE;
                        snooze_cnt_d = '0;
                    end else if (sec_tick) begin
                        if (snz_last) begin
                            state_d      = S_RING;
                            ring_cnt_d   = '0;
                            snooze_cnt_d = '0;
                        end else begin
                            snooze_cnt_d = snooze_cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d      = S_IDLE;
                    ring_cnt_d   = '0;
                    snooze_cnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            state_q      <= S_IDLE;
            ring_cnt_q   <= '0;
            snooze_cnt_q <= '0;
            active_id_q  <= '0;
        end else begin
            state_q      <= state_d;
            ring_cnt_q   <= ring_cnt_d;
            snooze_cnt_q <= snooze_cnt_d;
            active_id_q  <= active_id_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign ringing    = (state_q == S_RING);
    assign snoozing   = (state_q == S_SNOOZE);
    assign active_id  = active_id_q;
    assign armed_mask = slot_armed;

    beep_gen #(
        .BEEP_DIV (BEEP_DIV)
    ) u_beep_gen (
        .clk_100MHz (clk_100MHz),
        .reset      (reset),
        .en         (ringing),
        .wave       (buzzer)
    );

endmodule

// File: tb/tb_multi_alarm_ctrl.sv
// Directed self-checking bench for multi_alarm_ctrl.
module tb_multi_alarm_ctrl;

    localparam int unsigned N = 4;

    logic       clk_100MHz;
    logic       reset;
    logic       sec_tick;
    logic [4:0] cur_hr;
    logic [5:0] cur_min;
    logic [5:0] cur_sec;
    logic       alarm_en;
    logic       wr_en;
    logic [1:0] wr_sel;
    logic [4:0] wr_hr;
    logic [5:0] wr_min;
    logic       wr_arm;
    logic       snooze;
    logic       dismiss;
    logic       buzzer;
    logic       ringing;
    logic       snoozing;
    logic [1:0] active_id;
    logic [3:0] armed_mask;

    int tests;
    int fails;

    multi_alarm_ctrl #(
        .NUM_ALARMS (N),
        .SNOOZE_SEC (3),
        .RING_SEC   (5),
        .BEEP_DIV   (4)
    ) dut (
        .clk_100MHz (clk_100MHz),
        .reset      (reset),
        .sec_tick   (sec_tick),
        .cur_hr     (cur_hr),
        .cur_min    (cur_min),
        .cur_sec    (cur_sec),
        .alarm_en   (alarm_en),
        .wr_en      (wr_en),
        .wr_sel     (wr_sel),
        .wr_hr      (wr_hr),
        .wr_min     (wr_min),
        .wr_arm     (wr_arm),
        .snooze     (snooze),
        .dismiss    (dismiss),
        .buzzer     (buzzer),
        .ringing    (ringing),
        .snoozing   (snoozing),
        .active_id  (active_id),
        .armed_mask (armed_mask)
    );

    initial clk_100MHz = 1'b0;
    always #5 clk_100MHz = ~clk_100MHz;

    // One clock; afterwards registers reflect the edge and inputs may change.
    task automatic cyc();
        @(posedge clk_100MHz);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [1:0] sel, input logic [4:0] h, input logic [5:0] m,
                      input logic arm);
        wr_sel = sel;
        wr_hr  = h;
        wr_min = m;
        wr_arm = arm;
        wr_en  = 1'b1;
        cyc();
        wr_en  = 1'b0;
    endtask

    // sec_tick pulse carrying the given time; returns one clk after the tick edge.
    task automatic tick_at(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
        cur_hr   = h;
        cur_min  = m;
        cur_sec  = s;
        sec_tick = 1'b1;
        cyc();
        sec_tick = 1'b0;
    endtask

    // Full nominal second: tick then nine quiet clocks.
    task automatic sec(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
        tick_at(h, m, s);
        idle(9);
    endtask

    task automatic pulse_snooze();
        snooze = 1'b1;
        cyc();
        snooze = 1'b0;
    endtask

    task automatic pulse_dismiss();
        dismiss = 1'b1;
        cyc();
        dismiss = 1'b0;
    endtask

    initial begin
        tests    = 0;
        fails    = 0;
        reset    = 1'b1;
        sec_tick = 1'b0;
        cur_hr   = '0;
        cur_min  = '0;
        cur_sec  = 6'd1;
        alarm_en = 1'b1;
        wr_en    = 1'b0;
        wr_sel   = '0;
        wr_hr    = '0;
        wr_min   = '0;
        wr_arm   = 1'b0;
        snooze   = 1'b0;
        dismiss  = 1'b0;
        idle(2);
        reset = 1'b0;

        // Reset state
        check("rst_ringing", 32'(ringing), 0);
        check("rst_snoozing", 32'(snoozing), 0);
        check("rst_buzzer", 32'(buzzer), 0);
        check("rst_active_id", 32'(active_id), 0);
        check("rst_armed_mask", 32'(armed_mask), 0);

        // 1. Slot1 07:30 armed, ring one clk after the 07:30:00 tick
        wr(2'd1, 5'd7, 6'd30, 1'b1);
        check("t1_armed_mask", 32'(armed_mask), 32'h2);
        sec(5'd7, 6'd29, 6'd59);
        check("t1_no_ring_early", 32'(ringing), 0);
        tick_at(5'd7, 6'd30, 6'd0);
        check("t1_ringing", 32'(ringing), 1);
        check("t1_active_id", 32'(active_id), 1);
        idle(3);
        check("t1_buz_low_phase", 32'(buzzer), 0);
        cyc();
        check("t1_buz_rise", 32'(buzzer), 1);
        idle(3);
        check("t1_buz_high_phase", 32'(buzzer), 1);
        cyc();
        check("t1_buz_fall", 32'(buzzer), 0);

        // 2. Snooze, then re-ring after 3 ticks with the same id
        pulse_snooze();
        check("t2_snoozing", 32'(snoozing), 1);
        check("t2_not_ringing", 32'(ringing), 0);
        check("t2_buzzer_off", 32'(buzzer), 0);
        sec(5'd7, 6'd30, 6'd1);
        sec(5'd7, 6'd30, 6'd2);
        check("t2_still_snoozing", 32'(snoozing), 1);
        tick_at(5'd7, 6'd30, 6'd3);
        check("t2_rering", 32'(ringing), 1);
        check("t2_rering_id", 32'(active_id), 1);
        check("t2_snooze_clear", 32'(snoozing), 0);
        idle(9);

        // 3. Ring timeout after 5 ticks
        sec(5'd7, 6'd30, 6'd4);
        sec(5'd7, 6'd30, 6'd5);
        sec(5'd7, 6'd30, 6'd6);
        sec(5'd7, 6'd30, 6'd7);
        check("t3_ring_before_timeout", 32'(ringing), 1);
        tick_at(5'd7, 6'd30, 6'd8);
        check("t3_timeout_ringing", 32'(ringing), 0);
        check("t3_timeout_snoozing", 32'(snoozing), 0);
        // Snooze and dismiss together: dismiss wins
        wr(2'd1, 5'd7, 6'd31, 1'b1);
        tick_at(5'd7, 6'd31, 6'd0);
        check("t3_ring_again", 32'(ringing), 1);
        snooze  = 1'b1;
        dismiss = 1'b1;
        cyc();
        snooze  = 1'b0;
        dismiss = 1'b0;
        check("t3_both_ringing", 32'(ringing), 0);
        check("t3_both_snoozing", 32'(snoozing), 0);
        pulse_snooze();
        check("t3_idle_snooze_noop", 32'(snoozing), 0);

        // 4. Priority and dropped match during RING
        wr(2'd0, 5'd6, 6'd0, 1'b1);
        wr(2'd2, 5'd6, 6'd0, 1'b1);
        wr(2'd3, 5'd6, 6'd1, 1'b1);
        check("t4_armed_mask", 32'(armed_mask), 32'hF);
        tick_at(5'd6, 6'd0, 6'd0);
        check("t4_ringing", 32'(ringing), 1);
        check("t4_lowest_id", 32'(active_id), 0);
        tick_at(5'd6, 6'd1, 6'd0);
        check("t4_drop_ringing", 32'(ringing), 1);
        check("t4_drop_id", 32'(active_id), 0);
        pulse_dismiss();
        check("t4_dismissed", 32'(ringing), 0);

        // 5. Illegal writes ignored; disarming active slot keeps ringing
        wr(2'd0, 5'd24, 6'd0, 1'b0);
        wr(2'd2, 5'd6, 6'd60, 1'b0);
        check("t5_bad_write_mask", 32'(armed_mask), 32'hF);
        tick_at(5'd6, 6'd0, 6'd0);
        check("t5_match_kept", 32'(ringing), 1);
        check("t5_match_id", 32'(active_id), 0);
        wr(2'd0, 5'd6, 6'd0, 1'b0);
        check("t5_disarm_active_ring", 32'(ringing), 1);
        check("t5_disarm_mask", 32'(armed_mask), 32'hE);
        pulse_dismiss();
        wr(2'd2, 5'd6, 6'd0, 1'b0);
        check("t5_mask_after", 32'(armed_mask), 32'hA);
        tick_at(5'd6, 6'd0, 6'd0);
        check("t5_disarmed_idle", 32'(ringing), 0);

        // 6. alarm_en drop silences; reset mid-SNOOZE clears everything
        tick_at(5'd6, 6'd1, 6'd0);
        check("t6_ring_slot3", 32'(ringing), 1);
        check("t6_id3", 32'(active_id), 3);
        idle(4);
        check("t6_buz_high", 32'(buzzer), 1);
        alarm_en = 1'b0;
        cyc();
        alarm_en = 1'b1;
        check("t6_en_buzzer", 32'(buzzer), 0);
        check("t6_en_ringing", 32'(ringing), 0);
        tick_at(5'd6, 6'd1, 6'd0);
        pulse_snooze();
        check("t6_snoozing", 32'(snoozing), 1);
        check("t6_snooze_id", 32'(active_id), 3);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        check("t6_rst_ringing", 32'(ringing), 0);
        check("t6_rst_snoozing", 32'(snoozing), 0);
        check("t6_rst_buzzer", 32'(buzzer), 0);
        check("t6_rst_id", 32'(active_id), 0);
        check("t6_rst_mask", 32'(armed_mask), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
